// File: rtl/cache_axi_line_mover.sv
// cache_axi_line_mover: AXI4 burst master moving 64-byte cache lines.
// Optionally writes back a dirty victim line (16-beat INCR write burst), then
// refills the missing line (16-beat read burst) and strobes it into the data
// array for one cycle.
// Build option: define CACHE_REFILL_WRAP_EN for a critical-word-first WRAP
// refill; otherwise the refill is a line-aligned INCR burst.
module cache_axi_line_mover #(
  parameter logic [3:0] AXI_ID     = 4'd0,
  parameter int         LINE_WORDS = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  // cache controller side
  input  logic         i_req,
  input  logic         i_wb_en,
  input  logic [31:0]  i_miss_addr,
  input  logic [31:0]  i_wb_addr,
  input  logic [511:0] i_cacheline_old,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_resp_err,
  output logic         o_refresh,
  output logic [511:0] o_cacheline_new,
  // AXI AW channel
  output logic [3:0]   o_awid,
  output logic [31:0]  o_awaddr,
  output logic [7:0]   o_awlen,
  output logic [2:0]   o_awsize,
  output logic [1:0]   o_awburst,
  output logic         o_awvalid,
  input  logic         i_awready,
  // AXI W channel
  output logic [31:0]  o_wdata,
  output logic [3:0]   o_wstrb,
  output logic         o_wlast,
  output logic         o_wvalid,
  input  logic         i_wready,
  // AXI B channel
  input  logic [1:0]   i_bresp,
  input  logic         i_bvalid,
  output logic         o_bready,
  // AXI AR channel
  output logic [3:0]   o_arid,
  output logic [31:0]  o_araddr,
  output logic [7:0]   o_arlen,
  output logic [2:0]   o_arsize,
  output logic [1:0]   o_arburst,
  output logic         o_arvalid,
  input  logic         i_arready,
  // AXI R channel
  input  logic [31:0]  i_rdata,
  input  logic [1:0]   i_rresp,
  input  logic         i_rlast,
  input  logic         i_rvalid,
  output logic         o_rready
);

  localparam logic [3:0] LAST_BEAT  = 4'(LINE_WORDS - 1);
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_FILL} state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [25:0]    r_miss_line;     // line address of the miss
  logic [25:0]    r_wb_line;       // line address of the victim
  logic [511:0]   r_wb_buf;        // victim line captured at request time
  logic [3:0]     r_beat;          // beats completed in the current burst
  logic [3:0]     r_idx;           // line word written by the next R beat
  logic           r_err;           // sticky response/protocol error
  logic           w_r_beat;
  logic           w_rlast_bad;
  logic [3:0]     w_idx_start;
  logic           w_unused;

`ifdef CACHE_REFILL_WRAP_EN
  localparam logic [1:0] BURST_WRAP = 2'b10;
  logic [3:0]     r_miss_word;     // critical word offset within the line
  assign w_idx_start = i_miss_addr[5:2];
  assign o_araddr    = {r_miss_line, r_miss_word, 2'b00};
  assign o_arburst   = BURST_WRAP;
  assign w_unused    = ^{i_miss_addr[1:0], i_wb_addr[5:0]};

  // Remember which word was missed so the WRAP burst starts on it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_miss_word <= '0;
    else if (r_state == S_IDLE && i_req)
      r_miss_word <= i_miss_addr[5:2];
  end
`else
  assign w_idx_start = 4'd0;
  assign o_araddr    = {r_miss_line, 6'b0};
  assign o_arburst   = BURST_INCR;
  assign w_unused    = ^{i_miss_addr[5:0], i_wb_addr[5:0]};
`endif

  // Fixed burst shape: 16 beats of 4 bytes, full strobes
  assign o_awid    = AXI_ID;
  assign o_awaddr  = {r_wb_line, 6'b0};
  assign o_awlen   = 8'd15;
  assign o_awsize  = 3'd2;
  assign o_awburst = BURST_INCR;
  assign o_wstrb   = 4'hF;
  assign o_wdata   = r_wb_buf[{r_beat, 5'b0} +: 32];
  assign o_arid    = AXI_ID;
  assign o_arlen   = 8'd15;
  assign o_arsize  = 3'd2;

  assign w_r_beat    = (r_state == S_R) && i_rvalid;
  // RLAST must mark exactly the final beat of the burst
  assign w_rlast_bad = i_rlast != (r_beat == LAST_BEAT);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  // Next-state decode and channel control outputs (all driven from state only)
  always_comb begin
    w_state_next = r_state;
    o_awvalid    = 1'b0;
    o_wvalid     = 1'b0;
    o_wlast      = 1'b0;
    o_bready     = 1'b0;
    o_arvalid    = 1'b0;
    o_rready     = 1'b0;
    o_done       = 1'b0;
    o_refresh    = 1'b0;
    o_resp_err   = 1'b0;
    o_busy       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: if (i_req) w_state_next = i_wb_en ? S_AW : S_AR;
      S_AW: begin
        o_awvalid = 1'b1;
        if (i_awready) w_state_next = S_W;
      end
      S_W: begin
        o_wvalid = 1'b1;
        o_wlast  = (r_beat == LAST_BEAT);
        if (i_wready && r_beat == LAST_BEAT) w_state_next = S_B;
      end
      S_B: begin
        o_bready = 1'b1;
        if (i_bvalid) w_state_next = S_AR;
      end
      S_AR: begin
        o_arvalid = 1'b1;
        if (i_arready) w_state_next = S_R;
      end
      S_R: begin
        o_rready = 1'b1;
        if (i_rvalid && r_beat == LAST_BEAT) w_state_next = S_FILL;
      end
      S_FILL: begin
        o_done       = 1'b1;
        o_refresh    = 1'b1;
        o_resp_err   = r_err;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Request capture, beat counting and error accumulation
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_miss_line <= '0;
      r_wb_line   <= '0;
      r_wb_buf    <= '0;
      r_beat      <= '0;
      r_idx       <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req) begin
            r_miss_line <= i_miss_addr[31:6];
            r_wb_line   <= i_wb_addr[31:6];
            if (i_wb_en) r_wb_buf <= i_cacheline_old;
            r_beat      <= '0;
            r_idx       <= w_idx_start;
          end
        end
        S_W: if (i_wready) r_beat <= r_beat + 4'd1;
        S_B: if (i_bvalid && i_bresp != 2'b00) r_err <= 1'b1;
        S_AR: r_beat <= '0;
        S_R: begin
          if (i_rvalid) begin
            r_beat <= r_beat + 4'd1;
            r_idx  <= r_idx + 4'd1;
            if (i_rresp != 2'b00 || w_rlast_bad) r_err <= 1'b1;
          end
        end
        S_FILL: r_err <= 1'b0;
        default: ;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LINE_WORDS; gi++) begin : g_line_word
      logic [31:0] r_word;
      // Capture an R beat into this word when the refill index selects it
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
          r_word <= '0;
        else if (w_r_beat && r_idx == 4'(gi))
          r_word <= i_rdata;
      end
      assign o_cacheline_new[gi*32 +: 32] = r_word;
    end
  endgenerate

endmodule

// File: doc/cache_axi_line_mover.md
# cache_axi_line_mover

AXI4 burst master that moves whole 64-byte cache lines between the two-way data array and the memory bus. On a miss it optionally writes back the evicted dirty line as a 16-beat INCR write burst, then refills the missing line with a 16-beat read burst. It presents the assembled line to the data array with a one-cycle `refresh` strobe. It sits between the cache controller FSM and the AXI crossbar, one instance per cache.

## Interface
Parameters:
- `AXI_ID` — default 4'd0 — value driven on `awid`/`arid`
- `LINE_WORDS` — default 16 — beats per line; fixed at 16, with a 512-bit line and a 6-bit byte offset

Ports:
- `clk`  in  1  — single clock
- `rst_n`  in  1  — reset, asynchronous, active-low
- `req`  in  1  — start a line transfer; sampled only in IDLE
- `wb_en`  in  1  — with `req`: perform write-back before the refill
- `miss_addr`  in  32  — byte address of the missing word
- `wb_addr`  in  32  — line address of the victim; bits [5:0] are ignored
- `cacheline_old`  in  512  — victim line; valid in the `req` cycle
- `busy`  out  1  — high from `req` acceptance through `done`
- `done`  out  1  — one-cycle pulse when the transfer completes
- `resp_err`  out  1  — pulses with `done` if any BRESP/RRESP≠OKAY, or on an RLAST mismatch
- `refresh`  out  1  — one-cycle write strobe to the data array
- `cacheline_new`  out  512  — refilled line; word *i* is in bits [32i+31:32i]
- AXI AW channel: `awid[3:0]`, `awaddr[31:0]`, `awlen[7:0]`=15, `awsize[2:0]`=2, `awburst[1:0]`=INCR, `awvalid` out; `awready` in
- AXI W channel: `wdata[31:0]`, `wstrb[3:0]`=4'hF, `wlast`, `wvalid` out; `wready` in
- AXI B channel: `bresp[1:0]`, `bvalid` in; `bready` out
- AXI AR channel: `arid[3:0]`, `araddr[31:0]`, `arlen[7:0]`=15, `arsize[2:0]`=2, `arburst[1:0]`, `arvalid` out; `arready` in
- AXI R channel: `rdata[31:0]`, `rresp[1:0]`, `rlast`, `rvalid` in; `rready` out

## Operation
- FSM states: IDLE, AW, W, B, AR, R, FILL.
- IDLE, `req`=1:
  - latch `miss_addr`, `wb_addr`, `wb_en`.
  - If `wb_en`=1, also latch `cacheline_old` into a 512-bit buffer.
  - Next state is AW if `wb_en`=1, otherwise AR.
- AW: `awvalid`=1 with `awaddr`={wb_addr[31:6],6'b0}. On `awready` → W.
- W:
  - `wvalid`=1; beat counter 0..15.
  - `wdata` = buffer word[counter]; `wlast`=1 at counter 15.
  - Counter advances on `wvalid&wready`. After beat 15 → B.
- B: `bready`=1. On `bvalid`, OR (`bresp`≠0) into the error flag → AR.
- AR:
  - `arvalid`=1, `araddr`={miss_addr[31:6],6'b0}, `arburst`=INCR.
  - On `arready` → R.
- R:
  - `rready`=1. Each `rvalid` beat writes `rdata` into line word[idx]; idx starts at 0 and increments mod 16.
  - OR (`rresp`≠0) into the error flag.
  - `rlast` must coincide with beat 15. `rlast` on any other beat, or no `rlast` on beat 15, sets the error flag.
  - The burst ends on the 16th beat regardless of `rlast`. → FILL.
- FILL:
  - `refresh`=1, `done`=1, and `resp_err`=error flag, all for one cycle.
  - `cacheline_new` holds the full line and stays stable until the next refill begins.
  - Clear the error flag → IDLE.
- `busy` = (state≠IDLE).
- A `req` outside IDLE is ignored.
- Valids hold their payload stable until handshake; no valid depends combinationally on a ready.

## Timing
- Reset (async, `rst_n`=0): state IDLE.
- Reset values: all `*valid`, `*ready`, `wlast`, `busy`, `done`, `refresh`, `resp_err` = 0; `cacheline_new` = 0; buffers and counters = 0.
- Reset asserted mid-burst aborts the transfer immediately; no completion pulse is generated.
- `awvalid`/`arvalid` rise the cycle after `req` is accepted, or the cycle after the previous state completes.
- Minimum latency with all readys tied high and zero-wait slave responses:
  - refill only: `req`@0, AR@1, R beats @2..17, FILL@18 (`refresh`/`done`).
  - with write-back: AW@1, W@2..17, B@18, AR@19, R@20..35, FILL@36.
- `bvalid` arriving in the same cycle as the last W handshake is accepted in B on the following cycle; the slave must hold `bvalid` until `bready`.
- `rvalid` gaps stall the counter; idx never wraps early.

## Configuration
- `CACHE_REFILL_WRAP_EN` defined: critical-word-first refill.
  - `araddr`={miss_addr[31:2],2'b0}, `arburst`=WRAP.
  - R-beat idx starts at `miss_addr[5:2]` and wraps 15→0.
  - `rlast` is still expected on the 16th beat.
- Not defined: `araddr` is line-aligned, `arburst`=INCR, idx starts at 0.
- The write-back path is identical in both builds.

## Test plan
- Refill only: `miss_addr`=0x1000_0044, slave returns words 0xA0..0xAF, zero wait → `araddr`=0x1000_0040; `refresh`@cycle 18; `cacheline_new[31:0]`=0xA0, `[511:480]`=0xAF; `resp_err`=0.
- Write-back + refill: `wb_addr`=0x2000_0080, `cacheline_old` word *i* = 0x100+*i* → `awaddr`=0x2000_0080; wdata 0x100..0x10F; `wlast` only on beat 15; AR issued only after `bvalid`; `done`@cycle 36.
- Backpressure: `awready` delayed 3 cycles, `wready` toggling, `rvalid` gaps of 2 cycles → payload stable while valid; line contents identical to the zero-wait case.
- Errors: `bresp`=2'b10, then `rlast` on beat 14 → `resp_err`=1 with `done`; next transfer `resp_err`=0.
- Reset mid-R at beat 7 → all outputs 0 immediately; no `refresh`; next `req` completes normally.
- `CACHE_REFILL_WRAP_EN`: `miss_addr`=0x1000_0078 → `araddr`=0x1000_0078, WRAP; first beat stored at word 14; line correct after wrap.
